// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_if
// Description : Ready/valid byte channel from the UART receiver to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    // Receiver side: produces the byte and valid, observes ready.
    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    // Consumer side: observes the byte and valid, drives ready.
    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver with two-flop line synchronizer, start-bit
//               glitch rejection, mid-symbol sampling, one-entry ready/valid
//               output register, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 1_000_000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        serial_in,
    uart_receiver_if.master  o_bus,
    output logic             framing_error,
    output logic             overrun
);

    // Clock cycles per symbol must be at least 4 for the counter scheme to hold.
    localparam int c_SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int c_SAMPLE_TIME      = c_SYMBOL_EDGE_TIME / 2;
    localparam int c_CNT_W            = $clog2(c_SYMBOL_EDGE_TIME);

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(c_SAMPLE_TIME - 1);
    localparam logic [c_CNT_W-1:0] c_EDGE_LAST   = c_CNT_W'(c_SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_framing_error;
    logic               r_overrun;

    logic               w_rx;
    logic               w_sample_pt;
    logic               w_edge_pt;
    logic               w_shift_en;
    logic               w_byte_done;
    logic               w_frame_err;

    assign w_rx        = r_sync2;
    assign w_sample_pt = (r_cnt == c_SAMPLE_LAST);
    assign w_edge_pt   = (r_cnt == c_EDGE_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and single-cycle event strobes.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) w_state_next = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (w_sample_pt) w_state_next = w_rx ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_edge_pt) begin
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_edge_pt) begin
                    if (w_rx) begin
                        w_byte_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it cannot retrigger a frame.
                if (w_rx) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Baud counter: restarts on every state change and at each data-bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_DATA && w_edge_pt)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Bit index and shift register; bits arrive LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else if (w_shift_en) begin
            r_shift[r_idx] <= w_rx;
            r_idx          <= r_idx + 3'd1;
        end else if (r_state != S_DATA) begin
            r_idx <= 3'd0;
        end
    end

    // One-entry output register with overrun and framing-error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_overrun       <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_overrun       <= 1'b0;
            r_framing_error <= w_frame_err;
            if (w_byte_done) begin
                if (!r_valid || o_bus.data_out_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && o_bus.data_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_bus.data_out       = r_data;
    assign o_bus.data_out_valid = r_valid;
    assign framing_error        = r_framing_error;
    assign overrun              = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver: table of single frames,
//               hand-written corner sequences, randomized frame stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic serial_in = 1'b1;
    logic ready_cmd = 1'b0;
    logic rnd_mode  = 1'b0;
    logic rnd_bit   = 1'b0;
    logic fe;
    logic ovr;

    always #5 clk = ~clk;

    uart_receiver_if bus ();
    assign bus.data_out_ready = rnd_mode ? rnd_bit : ready_cmd;

    uart_receiver #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (1_000_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .o_bus         (bus),
        .framing_error (fe),
        .overrun       (ovr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #2;
        rnd_bit = 1'($urandom_range(1, 0));
    end

    // Monitor: event counters and log of accepted bytes.
    int         n_vrise = 0;
    int         t_vrise = 0;
    int         n_fe    = 0;
    int         n_ovr   = 0;
    int         rx_n    = 0;
    logic [7:0] rx_log [0:63];
    logic       prev_v  = 1'b0;

    always @(negedge clk) begin
        if (bus.data_out_valid === 1'b1 && prev_v !== 1'b1) begin
            n_vrise = n_vrise + 1;
            t_vrise = cyc;
        end
        prev_v = bus.data_out_valid;
        if (bus.data_out_valid === 1'b1 && bus.data_out_ready === 1'b1 && rx_n < 64) begin
            rx_log[rx_n] = bus.data_out;
            rx_n = rx_n + 1;
        end
        if (fe === 1'b1)  n_fe  = n_fe + 1;
        if (ovr === 1'b1) n_ovr = n_ovr + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int t_start  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one 8N1 frame, each bit held for per clock cycles.
    task automatic send_frame(input logic [7:0] b, input int per, input bit stop_ok);
        logic [9:0] bits;
        bits    = {stop_ok, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            tick(per);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         per;
        bit         stop_ok;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs [7];

    int         base_v;
    int         base_fe;
    int         base_ovr;
    int         base_rx;
    int         lat;
    logic [7:0] exp_q [$];
    logic [7:0] rb;
    logic [9:0] cbits;
    int         rper;
    int         rgap;

    initial begin
        //            data   per  stop  #valid data   #fe
        vecs[0] = '{8'hA5, 100, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h96,  97, 1'b1, 1, 8'h96, 0};
        vecs[2] = '{8'h96, 103, 1'b1, 1, 8'h96, 0};
        vecs[3] = '{8'h00, 100, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 100, 1'b1, 1, 8'hFF, 0};
        vecs[5] = '{8'h81, 100, 1'b0, 0, 8'h00, 1};
        vecs[6] = '{8'h3C, 100, 1'b1, 1, 8'h3C, 0};

        // Reset values
        tick(3);
        chk("reset data_out", bus.data_out, 8'h00);
        chk("reset valid", bus.data_out_valid, 1'b0);
        chk("reset framing_error", fe, 1'b0);
        chk("reset overrun", ovr, 1'b0);
        rst = 1'b0;
        tick(5);

        // Table of single frames, consumer always ready
        ready_cmd = 1'b1;
        for (int i = 0; i < 7; i++) begin
            base_v   = n_vrise;
            base_fe  = n_fe;
            base_ovr = n_ovr;
            base_rx  = rx_n;
            send_frame(vecs[i].data, vecs[i].per, vecs[i].stop_ok);
            serial_in = 1'b1;
            tick(100);
            chk($sformatf("vec%0d valid count", i), n_vrise - base_v, vecs[i].exp_valid);
            chk($sformatf("vec%0d accepted count", i), rx_n - base_rx, vecs[i].exp_valid);
            chk($sformatf("vec%0d framing_error count", i), n_fe - base_fe, vecs[i].exp_fe);
            chk($sformatf("vec%0d overrun count", i), n_ovr - base_ovr, 0);
            if (vecs[i].exp_valid == 1) begin
                chk($sformatf("vec%0d data", i), rx_log[base_rx], vecs[i].exp_data);
                if (vecs[i].per == 100) begin
                    lat = t_vrise - t_start;
                    chk($sformatf("vec%0d latency %0d in 950..954", i, lat),
                        (lat >= 950 && lat <= 954), 1'b1);
                end
            end
        end

        // Back-to-back 00, FF, 55 with consumer stalled
        ready_cmd = 1'b0;
        tick(2);
        base_v   = n_vrise;
        base_fe  = n_fe;
        base_ovr = n_ovr;
        base_rx  = rx_n;
        send_frame(8'h00, 100, 1'b1);
        send_frame(8'hFF, 100, 1'b1);
        send_frame(8'h55, 100, 1'b1);
        tick(100);
        chk("b2b valid rises", n_vrise - base_v, 1);
        chk("b2b valid held", bus.data_out_valid, 1'b1);
        chk("b2b data_out kept", bus.data_out, 8'h00);
        chk("b2b overrun count", n_ovr - base_ovr, 2);
        chk("b2b framing_error count", n_fe - base_fe, 0);
        ready_cmd = 1'b1;
        tick(5);
        chk("b2b valid cleared", bus.data_out_valid, 1'b0);
        chk("b2b accepted count", rx_n - base_rx, 1);
        chk("b2b accepted data", rx_log[base_rx], 8'h00);

        // 20-cycle low glitch, then a real frame
        base_v  = n_vrise;
        base_fe = n_fe;
        base_rx = rx_n;
        serial_in = 1'b0;
        tick(20);
        serial_in = 1'b1;
        tick(300);
        chk("glitch valid rises", n_vrise - base_v, 0);
        chk("glitch framing_error", n_fe - base_fe, 0);
        send_frame(8'h3C, 100, 1'b1);
        tick(100);
        chk("post-glitch count", rx_n - base_rx, 1);
        chk("post-glitch data", rx_log[base_rx], 8'h3C);
        lat = t_vrise - t_start;
        chk($sformatf("post-glitch latency %0d in 950..954", lat), (lat >= 950 && lat <= 954), 1'b1);

        // Bad stop bit followed by a long break; 42 left pending afterwards
        ready_cmd = 1'b0;
        base_v  = n_vrise;
        base_fe = n_fe;
        send_frame(8'h81, 100, 1'b0);
        tick(3000);
        chk("break framing_error count", n_fe - base_fe, 1);
        chk("break valid rises", n_vrise - base_v, 0);
        serial_in = 1'b1;
        tick(200);
        send_frame(8'h42, 100, 1'b1);
        tick(100);
        chk("post-break valid", bus.data_out_valid, 1'b1);
        chk("post-break data", bus.data_out, 8'h42);
        chk("post-break framing_error count", n_fe - base_fe, 1);

        // Reset in the middle of data bit 6 of C3
        cbits   = {1'b1, 8'hC3, 1'b0};
        base_fe = n_fe;
        for (int i = 0; i < 7; i++) begin
            serial_in = cbits[i];
            tick(100);
        end
        serial_in = cbits[7];
        tick(50);
        rst = 1'b1;
        #1;
        chk("async reset data_out", bus.data_out, 8'h00);
        chk("async reset valid", bus.data_out_valid, 1'b0);
        tick(3);
        rst = 1'b0;
        base_v = n_vrise;
        tick(50);
        serial_in = cbits[8];
        tick(100);
        serial_in = cbits[9];
        tick(100);
        tick(300);
        chk("after reset valid rises", n_vrise - base_v, 0);
        chk("after reset framing_error", n_fe - base_fe, 0);
        ready_cmd = 1'b1;
        base_rx   = rx_n;
        send_frame(8'h7E, 100, 1'b1);
        tick(100);
        chk("post-reset count", rx_n - base_rx, 1);
        chk("post-reset data", rx_log[base_rx], 8'h7E);

        // Randomized stream: bytes, baud within +-3%, idle gaps, random ready
        rnd_mode = 1'b1;
        base_rx  = rx_n;
        base_fe  = n_fe;
        base_ovr = n_ovr;
        for (int k = 0; k < 10; k++) begin
            rb   = 8'($urandom);
            rper = $urandom_range(103, 97);
            rgap = $urandom_range(40, 0);
            exp_q.push_back(rb);
            send_frame(rb, rper, 1'b1);
            tick(rgap);
        end
        tick(200);
        rnd_mode = 1'b0;
        chk("random accepted count", rx_n - base_rx, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            chk($sformatf("random byte %0d", j), rx_log[base_rx + j], exp_q[j]);
        end
        chk("random framing_error count", n_fe - base_fe, 0);
        chk("random overrun count", n_ovr - base_ovr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
